// File: rtl/rng_sched.sv
`default_nettype none
// ============================================================================
//  Module   : rng_sched
//  Purpose  : Shares one three-component Tausworthe RNG between NUM_REQ
//             consumers. Round-robin arbitrates per-cycle random-word
//             requests, stepping the RNG once per grant so every grant gets
//             a fresh 32-bit word, and runs the six-word seed-load protocol
//             into the RNG configuration shift chain.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock          in   1        rising-edge clock
//    reset_n        in   1        asynchronous active-low reset
//    req            in   NUM_REQ  per-requester request, held until granted
//    gnt            out  NUM_REQ  registered one-hot grant pulse
//    rand_data      out  32       registered random word for the grantee
//    rand_valid     out  1        qualifies rand_data, coincident with gnt
//    seed_start     in   1        pulse, begins a seed load
//    seed_valid     in   1        seed word valid
//    seed_data      in   16       seed word
//    seed_ready     out  1        high while seed words are accepted
//    busy           out  1        high while loading (or warming up)
//    rng_enable     out  1        steps the RNG
//    rng_cfg_valid  out  1        RNG config_in_valid
//    rng_cfg_data   out  16       RNG config_in
//    rng_rand       in   32       RNG rand_out (current state)
// ----------------------------------------------------------------------------
//  Build option
//    RNG_SCHED_WARMUP_EN  when defined, the RNG is stepped WARMUP_CYCLES
//                         times after each seed load before requests are
//                         served again.
// ============================================================================

module rng_sched #(
  parameter int NUM_REQ       = 4,
  parameter int SEED_WORDS    = 6,
  parameter int WARMUP_CYCLES = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [31:0]        rand_data,
  output logic               rand_valid,
  input  logic               seed_start,
  input  logic               seed_valid,
  input  logic [15:0]        seed_data,
  output logic               seed_ready,
  output logic               busy,
  output logic               rng_enable,
  output logic               rng_cfg_valid,
  output logic [15:0]        rng_cfg_data,
  input  logic [31:0]        rng_rand
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(SEED_WORDS + 1);

  // Elaboration-time guard on the supported configuration range.
  if (NUM_REQ < 2 || NUM_REQ > 8 || SEED_WORDS < 1 || WARMUP_CYCLES < 1) begin : g_param_check
    $error("rng_sched: unsupported parameter value");
  end

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_LOAD = 2'd1
`ifdef RNG_SCHED_WARMUP_EN
    ,
    S_WARM = 2'd2
`endif
  } state_t;

  state_t             state, state_nx;
  logic [PTR_W-1:0]   ptr, ptr_nx;
  logic [CNT_W-1:0]   word_cnt, word_cnt_nx;
  logic               grant_now;
  logic               found;
  logic [PTR_W-1:0]   sel;

`ifdef RNG_SCHED_WARMUP_EN
  localparam int WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  logic [WARM_W-1:0]  warm_cnt, warm_cnt_nx;
`endif

  // --------------------------------------------------------------------------
  // Round-robin selection: first set request at or above the pointer,
  // wrapping around. Indices are folded by subtraction so NUM_REQ need not
  // be a power of two.
  // --------------------------------------------------------------------------
  always_comb begin
    int idx;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx[PTR_W-1:0]]) begin
        found = 1'b1;
        sel   = idx[PTR_W-1:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_RUN;
      ptr      <= '0;
      word_cnt <= '0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      word_cnt <= word_cnt_nx;
    end
  end

`ifdef RNG_SCHED_WARMUP_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) warm_cnt <= '0;
    else          warm_cnt <= warm_cnt_nx;
  end
`endif

  // --------------------------------------------------------------------------
  // Next-state and combinational outputs. The RNG enable and the config
  // valid are produced in mutually exclusive states, so they can never be
  // high together.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx      = state;
    ptr_nx        = ptr;
    word_cnt_nx   = word_cnt;
    grant_now     = 1'b0;
    rng_enable    = 1'b0;
    rng_cfg_valid = 1'b0;
    rng_cfg_data  = '0;
    seed_ready    = 1'b0;
    busy          = 1'b0;
`ifdef RNG_SCHED_WARMUP_EN
    warm_cnt_nx   = warm_cnt;
`endif

    case (state)
      S_RUN: begin
        // A seed request wins over any pending word request that cycle.
        if (seed_start) begin
          state_nx = S_LOAD;
        end else if (found) begin
          rng_enable = 1'b1;
          grant_now  = 1'b1;
          ptr_nx     = (sel == PTR_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
        end
      end

      S_LOAD: begin
        seed_ready    = 1'b1;
        busy          = 1'b1;
        rng_cfg_valid = seed_valid;
        rng_cfg_data  = seed_data;
        if (seed_valid) begin
          if (word_cnt == CNT_W'(SEED_WORDS - 1)) begin
            word_cnt_nx = '0;
`ifdef RNG_SCHED_WARMUP_EN
            state_nx    = S_WARM;
            warm_cnt_nx = '0;
`else
            state_nx    = S_RUN;
`endif
          end else begin
            word_cnt_nx = word_cnt + 1'b1;
          end
        end
      end

`ifdef RNG_SCHED_WARMUP_EN
      S_WARM: begin
        busy       = 1'b1;
        rng_enable = 1'b1;
        if (warm_cnt == WARM_W'(WARMUP_CYCLES - 1)) begin
          warm_cnt_nx = '0;
          state_nx    = S_RUN;
        end else begin
          warm_cnt_nx = warm_cnt + 1'b1;
        end
      end
`endif

      default: begin
        state_nx = S_RUN;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registered grant and data. rng_rand is sampled in the same cycle the
  // enable is raised, i.e. the value before the step; the step itself
  // prepares the next word for the following grant.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gnt        <= '0;
      rand_data  <= '0;
      rand_valid <= 1'b0;
    end else begin
      rand_valid <= grant_now;
      if (grant_now) begin
        gnt       <= NUM_REQ'(1) << sel;
        rand_data <= rng_rand;
      end else begin
        gnt       <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rng_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_rng_sched
//  Purpose  : Directed self-checking bench for rng_sched, with a behavioural
//             Tausworthe RNG (config shift chain + taus88 step) attached.
//  Revision : 1.0  initial release
// ============================================================================

module tb_rng_sched;

  localparam int NUM_REQ = 4;

  logic               clock = 1'b0;
  logic               reset_n;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [31:0]        rand_data;
  logic               rand_valid;
  logic               seed_start;
  logic               seed_valid;
  logic [15:0]        seed_data;
  logic               seed_ready;
  logic               busy;
  logic               rng_enable;
  logic               rng_cfg_valid;
  logic [15:0]        rng_cfg_data;
  logic [31:0]        rng_rand;

  int vectors = 0;
  int errors  = 0;
  int en_cnt  = 0;
  int cfg_cnt = 0;

  always #5 clock = ~clock;

  rng_sched #(.NUM_REQ(NUM_REQ), .SEED_WORDS(6), .WARMUP_CYCLES(8)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .req           (req),
    .gnt           (gnt),
    .rand_data     (rand_data),
    .rand_valid    (rand_valid),
    .seed_start    (seed_start),
    .seed_valid    (seed_valid),
    .seed_data     (seed_data),
    .seed_ready    (seed_ready),
    .busy          (busy),
    .rng_enable    (rng_enable),
    .rng_cfg_valid (rng_cfg_valid),
    .rng_cfg_data  (rng_cfg_data),
    .rng_rand      (rng_rand)
  );

  // ---------------- behavioural RNG ----------------
  function automatic logic [95:0] taus_step(input logic [95:0] st);
    logic [31:0] a, b, c, t;
    {a, b, c} = st;
    t = ((a << 13) ^ a) >> 19;  a = ((a & 32'hFFFFFFFE) << 12) ^ t;
    t = ((b << 2)  ^ b) >> 25;  b = ((b & 32'hFFFFFFF8) << 4)  ^ t;
    t = ((c << 3)  ^ c) >> 11;  c = ((c & 32'hFFFFFFF0) << 17) ^ t;
    return {a, b, c};
  endfunction

  function automatic logic [31:0] taus_out_after(input int n);
    logic [95:0] st;
    st = {32'hFFFFFC02, 32'hFFFFFC03, 32'hFFFFFC04};
    for (int i = 0; i < n; i++) st = taus_step(st);
    return st[95:64] ^ st[63:32] ^ st[31:0];
  endfunction

  logic [31:0] s1, s2, s3;
  logic        rng_init;
  assign rng_rand = s1 ^ s2 ^ s3;

  always @(posedge clock) begin
    if (rng_init) begin
      s1 <= 32'hFFFFFC02; s2 <= 32'hFFFFFC03; s3 <= 32'hFFFFFC04;
    end else if (rng_cfg_valid) begin
      {s1, s2, s3} <= {rng_cfg_data, s1, s2, s3[31:16]};
    end else if (rng_enable) begin
      {s1, s2, s3} <= taus_step({s1, s2, s3});
    end
    if (rng_enable)    en_cnt  <= en_cnt + 1;
    if (rng_cfg_valid) cfg_cnt <= cfg_cnt + 1;
  end

  // ---------------- helpers ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, " gnt"},       32'(gnt), 32'h0);
    check_eq({tag, " rvalid"},    32'(rand_valid), 32'h0);
    check_eq({tag, " rdata"},     rand_data, 32'h0);
    check_eq({tag, " busy"},      32'(busy), 32'h0);
    check_eq({tag, " sready"},    32'(seed_ready), 32'h0);
    check_eq({tag, " en"},        32'(rng_enable), 32'h0);
    check_eq({tag, " cfgv"},      32'(rng_cfg_valid), 32'h0);
    check_eq({tag, " cfgd"},      32'(rng_cfg_data), 32'h0);
  endtask

  // Wait out a busy period with a cycle bound, requiring no grants meanwhile.
  task automatic wait_not_busy(input string tag);
    int n;
    n = 0;
    while (busy && n < 40) begin
      check_eq({tag, " gnt during busy"}, 32'(gnt), 32'h0);
      tick();
      n++;
    end
    check_eq({tag, " busy timeout"}, 32'(busy), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int          en0;
    logic [31:0] exp_word;

    reset_n = 1'b0; rng_init = 1'b1;
    req = '0; seed_start = 1'b0; seed_valid = 1'b0; seed_data = '0;
    tick(); tick();
    check_idle_outputs("reset");
    rng_init = 1'b0;
    reset_n  = 1'b1;
    tick();

    // ---- single request from reset seeds ----
    req = 4'b0001;
    #1 check_eq("t1 enable", 32'(rng_enable), 32'h1);
    tick();
    check_eq("t1 gnt",    32'(gnt), 32'h1);
    check_eq("t1 rdata",  rand_data, 32'hFFFFFC05);
    check_eq("t1 rvalid", 32'(rand_valid), 32'h1);
    req = '0;
    #1 check_eq("t1 enable off", 32'(rng_enable), 32'h0);
    tick();
    check_eq("t1 gnt off",    32'(gnt), 32'h0);
    check_eq("t1 rvalid off", 32'(rand_valid), 32'h0);
    check_eq("t1 rdata hold", rand_data, 32'hFFFFFC05);

    // pointer back to 0 (RNG model is not reset)
    reset_n = 1'b0; #1; reset_n = 1'b1;
    tick();

    // ---- all four requesting: rotation and fresh words ----
    en0 = en_cnt;
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq($sformatf("t2 gnt%0d", k), 32'(gnt), 32'(1) << k);
      check_eq($sformatf("t2 rdata%0d", k), rand_data, taus_out_after(k + 1));
      check_eq($sformatf("t2 rvalid%0d", k), 32'(rand_valid), 32'h1);
    end
    req = '0;
    tick();
    check_eq("t2 gnt off", 32'(gnt), 32'h0);
    check_eq("t2 enables", 32'(en_cnt - en0), 32'd4);

    // ---- back-to-back seed load ----
    en0 = cfg_cnt;
    seed_start = 1'b1;
    #1 check_eq("t3 start no enable", 32'(rng_enable), 32'h0);
    tick();
    seed_start = 1'b0;
    check_eq("t3 busy",   32'(busy), 32'h1);
    check_eq("t3 sready", 32'(seed_ready), 32'h1);
    for (int w = 1; w <= 6; w++) begin
      seed_valid = 1'b1; seed_data = 16'(w);
      #1;
      check_eq($sformatf("t3 cfgv%0d", w), 32'(rng_cfg_valid), 32'h1);
      check_eq($sformatf("t3 cfgd%0d", w), 32'(rng_cfg_data), 32'(w));
      check_eq($sformatf("t3 en%0d", w),   32'(rng_enable), 32'h0);
      tick();
    end
    seed_valid = 1'b0;
    check_eq("t3 cfg count", 32'(cfg_cnt - en0), 32'd6);
    check_eq("t3 s3 low",    32'(s3[15:0]), 32'h0001);
    check_eq("t3 s1 high",   32'(s1[31:16]), 32'h0006);
`ifdef RNG_SCHED_WARMUP_EN
    req = 4'b1111;
    en0 = en_cnt;
    for (int c = 0; c < 8; c++) begin
      check_eq($sformatf("warm en%0d", c),     32'(rng_enable), 32'h1);
      check_eq($sformatf("warm busy%0d", c),   32'(busy), 32'h1);
      check_eq($sformatf("warm sready%0d", c), 32'(seed_ready), 32'h0);
      check_eq($sformatf("warm gnt%0d", c),    32'(gnt), 32'h0);
      tick();
    end
    check_eq("warm exit busy",  32'(busy), 32'h0);
    check_eq("warm exit gnt",   32'(gnt), 32'h0);
    check_eq("warm step count", 32'(en_cnt - en0), 32'd8);
    tick();
    check_eq("warm first gnt", 32'(gnt), 32'h1);
    req = '0;
    tick();
`else
    check_eq("t3 busy after", 32'(busy), 32'h0);
    check_eq("t3 sready after", 32'(seed_ready), 32'h0);
`endif

    // ---- load with gaps while a request is pending ----
    req = 4'b0010; seed_start = 1'b1;
    #1 check_eq("t4 start no enable", 32'(rng_enable), 32'h0);
    tick();
    seed_start = 1'b0;
    check_eq("t4 no gnt at start", 32'(gnt), 32'h0);
    for (int w = 0; w < 6; w++) begin
      seed_valid = 1'b1; seed_data = 16'h0010 + 16'(w);
      #1 check_eq($sformatf("t4 en w%0d", w), 32'(rng_enable), 32'h0);
      tick();
      seed_valid = 1'b0;
      check_eq($sformatf("t4 gnt w%0d", w), 32'(gnt), 32'h0);
      if (w < 5) begin
        for (int g = 0; g < 2; g++) begin
          check_eq($sformatf("t4 gap busy w%0d", w), 32'(busy), 32'h1);
          tick();
          check_eq($sformatf("t4 gap gnt w%0d", w), 32'(gnt), 32'h0);
        end
      end
    end
    wait_not_busy("t4");
    check_eq("t4 enable in run", 32'(rng_enable), 32'h1);
    exp_word = rng_rand;
    tick();
    check_eq("t4 gnt", 32'(gnt), 32'h2);
    check_eq("t4 rdata", rand_data, exp_word);
    req = '0;
    tick();

    // ---- reset in the middle of a load, then a full restart ----
    seed_start = 1'b1;
    tick();
    seed_start = 1'b0;
    for (int w = 0; w < 3; w++) begin
      seed_valid = 1'b1; seed_data = 16'h00A0 + 16'(w);
      tick();
    end
    seed_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1 check_idle_outputs("t5 async");
    tick();
    reset_n = 1'b1;
    tick();
    check_eq("t5 run after reset", 32'(busy), 32'h0);
    seed_start = 1'b1;
    tick();
    seed_start = 1'b0;
    for (int w = 0; w < 6; w++) begin
      seed_valid = 1'b1; seed_data = 16'h00B0 + 16'(w);
      check_eq($sformatf("t5 busy w%0d", w), 32'(busy), 32'h1);
      tick();
    end
    seed_valid = 1'b0;
    check_eq("t5 s3 low",  32'(s3[15:0]), 32'h00B0);
    check_eq("t5 s1 high", 32'(s1[31:16]), 32'h00B5);
`ifndef RNG_SCHED_WARMUP_EN
    check_eq("t5 busy after", 32'(busy), 32'h0);
`endif
    wait_not_busy("t5");
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rng_sched.md
Name: rng_sched

Overview:
- Sequences and shares one three-component Tausworthe RNG instance between NUM_REQ consumers.
- Round-robin arbitrates per-cycle random-word requests and drives the RNG enable so each grant receives a fresh 32-bit value.
- Runs the RNG seed-load protocol: six 16-bit words shifted into the RNG config chain.
- Sits between the RNG datapath and the consuming engines.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- SEED_WORDS, 6: 16-bit words per seed load (3 seeds x 2 halves).
- WARMUP_CYCLES, 8: RNG steps after a seed load; used only with RNG_SCHED_WARMUP_EN.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request; held until granted.
- gnt  out  NUM_REQ  registered one-hot grant pulse.
- rand_data  out  32  registered random word for the granted requester.
- rand_valid  out  1  qualifies rand_data; coincident with gnt.
- seed_start  in  1  pulse; begins a seed load.
- seed_valid  in  1  seed word valid.
- seed_data  in  16  seed word.
- seed_ready  out  1  high while the block accepts seed words.
- busy  out  1  high in LOAD or WARM.
- rng_enable  out  1  to RNG enable; steps the generator.
- rng_cfg_valid  out  1  to RNG config_in_valid.
- rng_cfg_data  out  16  to RNG config_in.
- rng_rand  in  32  from RNG rand_out; reflects current RNG state.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=RUN, round-robin pointer=0, word counter=0.
  - gnt=0, rand_data=0, rand_valid=0, seed_ready=0, busy=0.
  - rng_enable=0, rng_cfg_valid=0, rng_cfg_data=0.
- Reset mid-load abandons the load. RNG keeps partially shifted seeds; the caller must restart the load.
- States: RUN, LOAD, WARM.
- RUN:
  - seed_start=1 -> LOAD next cycle. No grant that cycle, even if req is nonzero.
  - Otherwise, if any req bit is set, select the first set bit searching from the pointer upward with wrap.
  - Same cycle: rng_enable=1 (combinational), sample rng_rand.
  - Next cycle: gnt[i]=1, rand_data=sampled rng_rand, rand_valid=1. Latency req->gnt = 1 cycle.
  - Pointer <= (i+1) mod NUM_REQ. At most one grant per cycle; sustained throughput 1 word/cycle.
  - No req: rng_enable=0; next cycle gnt=0, rand_valid=0, rand_data holds its last value.
  - A req bit dropped before being granted is simply not considered.
- LOAD:
  - seed_ready=1, busy=1, rng_enable=0.
  - rng_cfg_valid = seed_valid; rng_cfg_data = seed_data (combinational pass-through).
  - Each seed_valid&&seed_ready increments the counter. Gaps in seed_valid are allowed.
  - After the SEED_WORDS-th accepted word: counter=0 and state -> WARM (macro defined) or RUN (macro undefined).
  - Word ordering: word 0 ends in s3[15:0], word 5 ends in s1[31:16].
- rng_cfg_valid and rng_enable are never high in the same cycle.
- seed_start is ignored in LOAD and WARM. req is ignored (no grants) in LOAD and WARM.

Optional Feature:
- Macro: RNG_SCHED_WARMUP_EN.
- Defined:
  - After the last seed word, state WARM holds rng_enable=1 for exactly WARMUP_CYCLES cycles, with busy=1, no grants, seed_ready=0.
  - Then RUN.
- Undefined: WARM state and its counter are absent; LOAD goes directly to RUN; busy drops the cycle after the last word.

Test Plan:
- RNG reset seeds (FFFFFC02/03/04), req=4'b0001 for 1 cycle -> one rng_enable pulse; next cycle gnt=4'b0001, rand_data=32'hFFFFFC05, rand_valid=1; following cycle gnt=0.
- req=4'b1111 held 4 cycles -> gnt sequence 0001, 0010, 0100, 1000; four distinct rand_data values; 4 rng_enable cycles.
- Macro undefined: seed_start, then words 16'h0001..16'h0006 back-to-back:
  - rng_cfg_valid high 6 cycles.
  - RNG s3[15:0]=16'h0001, s1[31:16]=16'h0006.
  - busy=0 after the 6th word.
- seed_start with req=4'b0010 held; seed words with 2-cycle seed_valid gaps -> no gnt until busy=0, then gnt=4'b0010 one cycle later.
- reset_n low after 3 accepted seed words -> all outputs 0 immediately; state RUN; a later seed_start restarts counting at word 0.
- Macro defined, WARMUP_CYCLES=8: after the 6th word, rng_enable high exactly 8 cycles with req=4'b1111 and no gnt; first grant on the cycle after WARM exits.
